// File: rtl/ball_launch_ctrl_if.sv
// Signal bundle between the power FSM / lane display (master) and the launch controller (slave).
interface ball_launch_ctrl_if #(
  parameter int unsigned POS_W = 4
);
  logic             tick;
  logic             throw_btn;
  logic [2:0]       pow_lvl;
  logic             ack;
  logic             charging;
  logic             rolling;
  logic             done;
  logic [2:0]       launched_lvl;
  logic [POS_W-1:0] ball_pos;

  modport master (
    output tick, throw_btn, pow_lvl, ack,
    input  charging, rolling, done, launched_lvl, ball_pos
  );

  modport slave (
    input  tick, throw_btn, pow_lvl, ack,
    output charging, rolling, done, launched_lvl, ball_pos
  );
endinterface

// File: rtl/ball_launch_ctrl.sv
// Latches power level on throw-button release, then steps the ball down the lane at a
// power-dependent tick rate and holds the finished roll until downstream acknowledges.
module ball_launch_ctrl #(
  parameter int unsigned LANE_LEN = 16,
  parameter int unsigned POS_W    = 4
) (
  input logic               clk,
  input logic               reset,
  ball_launch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCharge, StRoll, StDone} state_e;

  localparam logic [POS_W-1:0] LastPos = POS_W'(LANE_LEN - 1);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       step_q, step_d;
  logic [2:0]       lvl_q, lvl_d;
  logic             charging_q, rolling_q, done_q;

  logic [2:0]       lvl_clean;
  logic [1:0]       last_step;
  logic [POS_W-1:0] pos_inc;

  // Out-of-range levels launch at minimum power.
  assign lvl_clean = (bus.pow_lvl >= 3'd1 && bus.pow_lvl <= 3'd4) ? bus.pow_lvl : 3'd1;
  // Interval is 5-lvl ticks, so the terminal step count is 4-lvl.
  assign last_step = 2'(3'd4 - lvl_q);
  assign pos_inc   = pos_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    step_d  = step_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      StIdle: begin
        pos_d = '0;
        if (bus.throw_btn) state_d = StCharge;
      end
      StCharge: begin
        if (!bus.throw_btn) begin
          state_d = StRoll;
          lvl_d   = lvl_clean;
          step_d  = '0;
          pos_d   = '0;
        end
      end
      StRoll: begin
        if (bus.tick) begin
          if (step_q == last_step) begin
            step_d = '0;
            pos_d  = pos_inc;
            if (pos_inc == LastPos) state_d = StDone;
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end
      StDone: begin
        if (bus.ack) begin
          state_d = StIdle;
          pos_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      step_q     <= '0;
      lvl_q      <= 3'd1;
      charging_q <= 1'b0;
      rolling_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      lvl_q      <= lvl_d;
      charging_q <= (state_d == StCharge);
      rolling_q  <= (state_d == StRoll);
      done_q     <= (state_d == StDone);
    end
  end

  assign bus.charging     = charging_q;
  assign bus.rolling      = rolling_q;
  assign bus.done         = done_q;
  assign bus.launched_lvl = lvl_q;
  assign bus.ball_pos     = pos_q;

endmodule

// File: tb/tb_ball_launch_ctrl.sv
// Random and directed launches compared cycle by cycle against a tick-count reference model.
module tb_ball_launch_ctrl;
  localparam int unsigned LaneLen = 16;
  localparam int unsigned PosW    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ball_launch_ctrl_if #(.POS_W(PosW)) bif ();

  ball_launch_ctrl #(
    .LANE_LEN(LaneLen),
    .POS_W   (PosW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 charge, 2 roll, 3 done; position derived from tick count.
  int m_mode  = 0;
  int m_lvl   = 1;
  int m_ticks = 0;
  int m_pos   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sanitize(input int p);
    return (p >= 1 && p <= 4) ? p : 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!reset) begin
      m_mode = 0; m_lvl = 1; m_ticks = 0; m_pos = 0;
    end else begin
      case (m_mode)
        0: if (bif.throw_btn) m_mode = 1;
        1: if (!bif.throw_btn) begin
          m_mode = 2; m_lvl = sanitize(int'(bif.pow_lvl)); m_ticks = 0; m_pos = 0;
        end
        2: if (bif.tick) begin
          m_ticks++;
          m_pos = m_ticks / (5 - m_lvl);
          if (m_pos == LaneLen - 1) m_mode = 3;
        end
        default: if (bif.ack) begin
          m_mode = 0; m_pos = 0;
        end
      endcase
    end
    #1;
    check_eq("charging", int'(bif.charging), int'(m_mode == 1));
    check_eq("rolling", int'(bif.rolling), int'(m_mode == 2));
    check_eq("done", int'(bif.done), int'(m_mode == 3));
    check_eq("ball_pos", int'(bif.ball_pos), m_pos);
    check_eq("launched_lvl", int'(bif.launched_lvl), m_lvl);
  endtask

  task automatic launch_and_roll(input int pl, input int period, input bit toggle,
                                 input int exp_ticks);
    int cnt = 0;
    bit hit = 0;
    bif.throw_btn = 1'b1;
    bif.pow_lvl   = 3'($urandom);
    cyc();
    repeat ($urandom_range(0, 2)) cyc();
    bif.pow_lvl   = 3'(pl);
    bif.throw_btn = 1'b0;
    bif.tick      = 1'b1;  // tick on the release edge must not count
    cyc();
    check_eq("release_lvl", int'(bif.launched_lvl), sanitize(pl));
    check_eq("release_rolling", int'(bif.rolling), 1);
    for (int k = 0; k < 2000 && !hit; k++) begin
      bif.tick = ((k % period) == period - 1);
      if (toggle) bif.throw_btn = 1'($urandom);
      bif.pow_lvl = 3'($urandom);
      bif.ack     = 1'($urandom);
      cyc();
      if (bif.tick) cnt++;
      if (bif.done) hit = 1'b1;
    end
    bif.tick = 1'b0; bif.ack = 1'b0; bif.throw_btn = 1'b0;
    check_eq("done_seen", int'(hit), 1);
    check_eq("ticks_to_done", cnt, exp_ticks);
    check_eq("pos_at_done", int'(bif.ball_pos), LaneLen - 1);
  endtask

  task automatic do_ack(input bit hold_btn);
    repeat ($urandom_range(0, 3)) begin
      bif.tick = 1'($urandom);
      cyc();
    end
    bif.tick      = 1'b0;
    bif.ack       = 1'b1;
    bif.throw_btn = hold_btn;
    cyc();
    bif.ack = 1'b0;
    check_eq("ack_done_drop", int'(bif.done), 0);
    check_eq("ack_pos_clear", int'(bif.ball_pos), 0);
    check_eq("ack_idle_charging", int'(bif.charging), 0);
    if (hold_btn) begin
      cyc();
      check_eq("ack_hold_charge", int'(bif.charging), 1);
      bif.throw_btn = 1'b0;
      bif.pow_lvl   = 3'd4;
      cyc();
      check_eq("ack_hold_roll", int'(bif.rolling), 1);
      // Finish that roll so the next directed launch starts from idle.
      for (int k = 0; k < 200 && !bif.done; k++) begin
        bif.tick = 1'b1;
        cyc();
      end
      bif.tick = 1'b0;
      check_eq("ack_hold_relaunch_done", int'(bif.done), 1);
      bif.ack = 1'b1;
      cyc();
      bif.ack = 1'b0;
    end
  endtask

  initial begin
    bit reached;
    reset         = 1'b0;
    bif.tick      = 1'($urandom);
    bif.throw_btn = 1'($urandom);
    bif.pow_lvl   = 3'($urandom);
    bif.ack       = 1'($urandom);
    cyc();
    bif.tick      = 1'($urandom);
    bif.throw_btn = 1'($urandom);
    bif.pow_lvl   = 3'($urandom);
    bif.ack       = 1'($urandom);
    cyc();
    check_eq("rst_pos", int'(bif.ball_pos), 0);
    check_eq("rst_lvl", int'(bif.launched_lvl), 1);
    check_eq("rst_flags", int'({bif.charging, bif.rolling, bif.done}), 0);
    reset = 1'b1;
    bif.tick = 1'b0; bif.throw_btn = 1'b0; bif.ack = 1'b0;
    cyc();

    launch_and_roll(4, 3, 1'b0, 15);
    do_ack(1'b0);
    launch_and_roll(1, 2, 1'b0, 60);
    do_ack(1'b0);
    launch_and_roll(0, 1, 1'b0, 60);
    do_ack(1'b0);
    launch_and_roll(6, 1, 1'b0, 60);
    do_ack(1'b0);
    launch_and_roll(2, 3, 1'b1, 45);
    do_ack(1'b0);
    launch_and_roll(3, 1, 1'b0, 30);
    do_ack(1'b1);

    // Reset in the middle of a roll.
    bif.throw_btn = 1'b1;
    cyc();
    bif.throw_btn = 1'b0;
    bif.pow_lvl   = 3'd3;
    cyc();
    reached = 1'b0;
    for (int k = 0; k < 400 && !reached; k++) begin
      bif.tick = (k % 2 == 1);
      cyc();
      if (bif.ball_pos == PosW'(7)) reached = 1'b1;
    end
    check_eq("midroll_pos7", int'(reached), 1);
    bif.tick = 1'b1;
    reset    = 1'b0;
    cyc();
    check_eq("midroll_rst_pos", int'(bif.ball_pos), 0);
    check_eq("midroll_rst_lvl", int'(bif.launched_lvl), 1);
    check_eq("midroll_rst_rolling", int'(bif.rolling), 0);
    reset    = 1'b1;
    bif.tick = 1'b0;
    cyc();
    launch_and_roll(4, 1, 1'b0, 15);
    do_ack(1'b0);

    // Free-running random traffic, occasional reset.
    for (int k = 0; k < 1500; k++) begin
      reset         = ($urandom_range(0, 99) != 0);
      bif.tick      = 1'($urandom);
      bif.throw_btn = ($urandom_range(0, 3) == 0);
      bif.pow_lvl   = 3'($urandom);
      bif.ack       = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ball_launch_ctrl.md
# ball_launch_ctrl

Consumer end of the power-meter interface. Watches the throw button while the power FSM cycles `pow_lvl` 1→4. Latches the level present on release and rolls the ball down the lane: a position counter advances at a rate set by the latched power, then reports completion to the pin/score logic. Sits between the power FSM and the lane/pin display logic, clocked by the system clock with the half-second or faster `tick` strobe as its time base.

## Interface

Parameters:

- `LANE_LEN`, default 16: number of lane positions. Legal range is 2 ≤ `LANE_LEN` ≤ 2^`POS_W`.
- `POS_W`, default 4: width of `ball_pos`.

Ports:

- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: reset, synchronous, active-low.
- `tick`, input, 1: single-cycle time-base strobe, synchronous to `clk`.
- `throw_btn`, input, 1: throw button, active-high while held. Already synchronized and debounced.
- `pow_lvl`, input, 3: current power level from the power FSM. Legal values are 1–4.
- `ack`, input, 1: downstream has consumed the finished roll.
- `charging`, output, 1: high in CHARGE.
- `rolling`, output, 1: high in ROLL.
- `done`, output, 1: high in DONE.
- `launched_lvl`, output, 3: power level latched at release.
- `ball_pos`, output, POS_W: current lane position, 0 … `LANE_LEN`−1.

## Operation

States: IDLE, CHARGE, ROLL, DONE. `charging`, `rolling` and `done` are Moore decodes of the state register.

- **IDLE**
  - `throw_btn`=1 → CHARGE.
  - `ball_pos` is held at 0.
- **CHARGE**
  - `throw_btn`=0 → ROLL.
  - On the same edge: latch the level into `launched_lvl`, clear `step_cnt` to 0, keep `ball_pos` at 0.
  - Level sanitization: `pow_lvl` of 0 or 5–7 latches as 1; values 1–4 latch unchanged.
- **ROLL**
  - Step interval I = 5 − `launched_lvl` ticks per position (lvl4 → 1, lvl1 → 4).
  - On each `tick`: if `step_cnt` == I−1, then `ball_pos`+1 and `step_cnt`←0; otherwise `step_cnt`+1.
  - On the edge where `ball_pos` becomes `LANE_LEN`−1, state → DONE on that same edge.
  - `ball_pos` never exceeds `LANE_LEN`−1 and never wraps.
- **DONE**
  - `ball_pos` and `launched_lvl` are held.
  - `ack`=1 → IDLE; on that edge `ball_pos`←0.

Boundary rules:

- `throw_btn` is ignored in ROLL and DONE. A held button cannot relaunch until IDLE is re-entered.
- `ack` is ignored outside DONE.
- `ack` and a held button together in DONE → IDLE; the next cycle sees the button and enters CHARGE. No launch is skipped and none is double-counted.
- `tick` during CHARGE or IDLE has no effect.
- `pow_lvl` is sampled only on the release edge; changes during ROLL have no effect.

Reset (`reset`=0 at a rising edge) overrides everything, mid-roll included:

- state←IDLE
- `ball_pos`←0
- `step_cnt`←0
- `launched_lvl`←3'b001
- `charging`, `rolling`, `done` = 0 the following cycle

## Timing

- Release-to-ROLL latency: 1 clock after the edge where `throw_btn`=0 is sampled in CHARGE.
- Ticks from entering ROLL to DONE: (`LANE_LEN`−1)·I. With `LANE_LEN`=16: lvl4 = 15, lvl3 = 30, lvl2 = 45, lvl1 = 60.
- `ball_pos`=`LANE_LEN`−1 and `done`=1 become visible in the same cycle.
- DONE-to-IDLE: 1 clock after `ack` is sampled high. `done` drops in that cycle.
- One-clock CHARGE is legal: `throw_btn` high for exactly 1 cycle still launches.
- `tick` on the release edge is not counted; counting starts with the first `tick` sampled in ROLL.

## Test plan

- **Reset values:** hold `reset`=0 for 2 clocks with random inputs → `ball_pos`=0, `launched_lvl`=1, `charging`=`rolling`=`done`=0.
- **Full-power launch:** press, set `pow_lvl`=4, release; tick every 3 clocks → `launched_lvl`=4. `ball_pos` goes 0→15, one step per tick. `done`=1 exactly after the 15th tick. `ack` → IDLE with `ball_pos`=0.
- **Minimum power and sanitization:**
  - `pow_lvl`=1 at release → `done` after 60 ticks.
  - `pow_lvl`=0 or 6 at release → `launched_lvl`=1, with identical 60-tick timing.
- **Ignored button:** toggle `throw_btn` repeatedly during ROLL (lvl2) → no restart; `done` after 45 ticks.
- **Ack with button held:** in DONE, assert `ack` with `throw_btn`=1 → IDLE for 1 cycle, then CHARGE.
- **Reset mid-roll:** assert `reset`=0 while `ball_pos`=7 → all outputs at reset values next cycle. A fresh launch then behaves normally.
